apb_timer_slave: RTL and testbench
==================================

Name: apb_timer_slave

Overview:
- APB peripheral that sits directly downstream of the APB master, on one of its PSELx/PRDATAx/PREADYx slots.
- Provides a prescaled up-counter with a compare/auto-reload register, an update flag, and a level interrupt.
- All registers are accessed through the APB setup/access protocol with one fixed wait state.
- Address decode across slaves happens upstream. This block decodes only the PADDR offset bits.

Parameters:
- CNT_W, 32: width of the CNT and ARR registers (1..32). Read data is zero-extended to 32 bits.
- PSC_W, 16: width of the PSC register and of the internal prescaler counter (1..32).

Ports:
- PCLK     input   1   clock, all state on rising edge
- PRESET   input   1   reset, asynchronous, active-high
- PADDR    input   32  address; only PADDR[4:2] decoded, all other bits ignored
- PWRITE   input   1   1 = write, 0 = read
- PENABLE  input   1   access phase indicator
- PWDATA   input   32  write data
- PSEL     input   1   slave select from upstream decoder
- PRDATA   output  32  read data, valid only while PREADY=1
- PREADY   output  1   transfer-complete strobe
- irq      output  1   interrupt, level, = UIF & IRQ_EN

Behaviour:
- Reset (async, PRESET=1):
  - PRDATA=0, PREADY=0, irq=0.
  - CTRL=0, PSC=0, ARR=all-ones, CNT=0, UIF=0, prescaler counter=0.
- APB handshake, states IDLE -> WAIT -> DONE -> IDLE:
  - IDLE: PREADY=0. If PSEL & PENABLE & !PREADY, go to WAIT.
  - WAIT: lasts exactly one cycle, then go to DONE.
  - DONE: PREADY=1 for exactly one cycle. A write commits on the DONE clock edge. PRDATA carries the read value; it is 0 at all other times. Return to IDLE.
- Resulting timing: setup 1 cycle, access 3 cycles.
- Transfers are never back-to-back with zero idle. The master's PENABLE drop after PREADY returns the block to IDLE.
- If PSEL drops mid-transfer, the FSM returns to IDLE, no write commits, and PREADY stays 0.
- Register map (offset = PADDR[4:2]):
  - 0x00 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD. Other bits read 0.
  - 0x04 PSC: prescaler divisor minus 1, RW.
  - 0x08 ARR: compare/reload value, RW.
  - 0x0C CNT: current count, RW.
  - 0x10 STATUS: bit0 UIF. Write-1-to-clear; writing 0 has no effect.
  - 0x14–0x1C: unmapped. Reads return 0, writes are ignored, PREADY is still given.
- Prescaler:
  - While EN=1: if psc_cnt==PSC, set psc_cnt=0 and generate a tick; else psc_cnt+1.
  - While EN=0: psc_cnt holds.
  - Writing PSC, or a CTRL write that takes EN from 0 to 1, clears psc_cnt.
  - PSC=0 gives a tick every cycle.
- Counter, on tick:
  - If CNT==ARR: CNT=0 and UIF=1. If AUTO_RELOAD=0, EN is also cleared (one-shot).
  - Otherwise CNT=CNT+1 (modulo 2^CNT_W).
  - If CNT>ARR after a software write, counting continues and wraps through 0 before matching ARR.
- Simultaneous events:
  - APB write to CNT in the same cycle as a tick: the written value wins and the tick is dropped.
  - W1C of UIF in the same cycle as a UIF set: the set wins.
  - CTRL write in the same cycle as a one-shot EN clear: the written value wins.
- Reset asserted mid-transfer or mid-count: everything returns to reset values immediately; no partial write commits.
- irq is combinational from registered UIF and IRQ_EN; it has no path from APB inputs.

Decomposition:
- Shared package apb_timer_pkg holds:
  - register offset localparams (CTRL_OFS … STATUS_OFS),
  - CTRL bit-index constants,
  - APB FSM state enum typedef (IDLE, WAIT, DONE).
- One natural sub-module: timer_core, containing the prescaler, counter, and UIF/EN update logic with its write-override inputs. The top level holds the APB FSM, register decode and read mux.

Test Plan:
- Reset, then read all six offsets 0x00–0x14 -> PRDATA 0, 0, 0xFFFF_FFFF, 0, 0, 0. PREADY is high exactly one cycle, 3 cycles after PENABLE rises.
- Write PSC=3, ARR=4, then CTRL=0x7 -> CNT increments every 4 cycles. After 20 cycles UIF=1, irq=1, CNT=0, and counting continues.
- Same setup with CTRL=0x1 (one-shot) -> after the match CNT=0, UIF=1, EN reads 0, irq=0, and CNT stays 0 for a further 40 cycles.
- With UIF=1, write STATUS=0 -> UIF stays 1. Write STATUS=1 -> UIF=0 and irq=0. Force a W1C coincident with a match -> UIF reads 1.
- PSC=0, ARR=100, EN=1; write CNT=50 on the cycle a tick occurs -> next read gives 50 plus cycles elapsed, not 51 plus.
- Write CTRL=0x7 with PADDR=0x1000_0000 and 0x1000_1000 (upper bits differ) -> both hit CTRL. Write 0x18 -> no register changes, PREADY still pulses. Assert PRESET during WAIT -> PREADY never rises and registers read reset values.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer slave.
//   - Byte offsets of the register map (decoded from PADDR[4:2]).
//   - Bit positions inside CTRL.
//   - APB handshake state encoding.
package apb_timer_pkg;

  localparam logic [4:0] CTRL_OFS   = 5'h00;
  localparam logic [4:0] PSC_OFS    = 5'h04;
  localparam logic [4:0] ARR_OFS    = 5'h08;
  localparam logic [4:0] CNT_OFS    = 5'h0C;
  localparam logic [4:0] STATUS_OFS = 5'h10;

  localparam int unsigned CTRL_W          = 3;
  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned CTRL_AR_BIT     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_timer_slave_timer_core.sv
// Timer datapath: prescaler, up-counter with compare/auto-reload, UIF flag
// and CTRL register, plus the software write ports that override them.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_wdata               APB write data
//   i_wr_ctrl..i_wr_status one-cycle write strobes per register
//   o_ctrl, o_psc, o_arr, o_cnt, o_uif  register contents
module timer_core
  import apb_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PSC_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_wdata,
  input  logic              i_wr_ctrl,
  input  logic              i_wr_psc,
  input  logic              i_wr_arr,
  input  logic              i_wr_cnt,
  input  logic              i_wr_status,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [PSC_W-1:0]  o_psc,
  output logic [CNT_W-1:0]  o_arr,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_uif
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [PSC_W-1:0]  r_psc;
  logic [PSC_W-1:0]  r_psc_cnt;
  logic [CNT_W-1:0]  r_arr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_uif;

  logic w_en;
  logic w_tick;
  logic w_match;
  logic w_set_uif;
  logic w_en_rise;
  logic w_unused_wdata;

  assign w_unused_wdata = &{1'b0, i_wdata};

  always_comb begin
    w_en      = r_ctrl[CTRL_EN_BIT];
    w_tick    = w_en && (r_psc_cnt == r_psc);
    w_match   = (r_cnt == r_arr);
    // A CNT write in the same cycle swallows the tick, so no match either.
    w_set_uif = w_tick && w_match && !i_wr_cnt;
    w_en_rise = i_wr_ctrl && !w_en && i_wdata[CTRL_EN_BIT];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ctrl    <= '0;
      r_psc     <= '0;
      r_psc_cnt <= '0;
      r_arr     <= '1;
      r_cnt     <= '0;
      r_uif     <= 1'b0;
    end else begin
      if (i_wr_psc) r_psc <= i_wdata[PSC_W-1:0];
      if (i_wr_arr) r_arr <= i_wdata[CNT_W-1:0];

      if (i_wr_psc || w_en_rise) r_psc_cnt <= '0;
      else if (w_en)             r_psc_cnt <= w_tick ? '0 : r_psc_cnt + 1'b1;

      if (i_wr_cnt)    r_cnt <= i_wdata[CNT_W-1:0];
      else if (w_tick) r_cnt <= w_match ? '0 : r_cnt + 1'b1;

      // Hardware set has priority over software clear.
      if (w_set_uif)                       r_uif <= 1'b1;
      else if (i_wr_status && i_wdata[0])  r_uif <= 1'b0;

      // Software CTRL write has priority over the one-shot EN clear.
      if (i_wr_ctrl)                              r_ctrl <= i_wdata[CTRL_W-1:0];
      else if (w_set_uif && !r_ctrl[CTRL_AR_BIT]) r_ctrl[CTRL_EN_BIT] <= 1'b0;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_psc  = r_psc;
  assign o_arr  = r_arr;
  assign o_cnt  = r_cnt;
  assign o_uif  = r_uif;

endmodule

// File: rtl/apb_timer_slave.sv
// APB timer slave: APB handshake with one fixed wait state, register decode
// on PADDR[4:2], read mux, and the timer_core datapath.
// Ports:
//   PCLK, PRESET                 clock, async active-high reset
//   PADDR, PWRITE, PENABLE,
//   PWDATA, PSEL                 APB request from the master
//   PRDATA, PREADY               APB response (PRDATA is 0 unless PREADY)
//   irq                          level interrupt = UIF & IRQ_EN
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PSC_W = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq
);

  apb_state_t        r_state;
  logic              r_pready;
  logic [31:0]       r_prdata;

  logic [4:0]        w_ofs;
  logic              w_commit;
  logic [31:0]       w_rdata;
  logic [CTRL_W-1:0] w_ctrl;
  logic [PSC_W-1:0]  w_psc;
  logic [CNT_W-1:0]  w_arr;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_uif;
  logic              w_unused_addr;

  assign w_unused_addr = &{1'b0, PADDR[31:5], PADDR[1:0]};
  assign w_ofs         = {PADDR[4:2], 2'b00};
  // Writes land on the edge that ends the DONE cycle.
  assign w_commit      = (r_state == DONE) && PSEL && PWRITE;

  always_comb begin
    w_rdata = '0;
    case (w_ofs)
      CTRL_OFS:   w_rdata = 32'(w_ctrl);
      PSC_OFS:    w_rdata = 32'(w_psc);
      ARR_OFS:    w_rdata = 32'(w_arr);
      CNT_OFS:    w_rdata = 32'(w_cnt);
      STATUS_OFS: w_rdata = 32'(w_uif);
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state  <= IDLE;
      r_pready <= 1'b0;
      r_prdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pready <= 1'b0;
          r_prdata <= '0;
          if (PSEL && PENABLE && !r_pready) r_state <= WAIT;
        end
        WAIT: begin
          if (PSEL && PENABLE) begin
            r_state  <= DONE;
            r_pready <= 1'b1;
            r_prdata <= PWRITE ? '0 : w_rdata;
          end else begin
            r_state  <= IDLE;
          end
        end
        DONE: begin
          r_state  <= IDLE;
          r_pready <= 1'b0;
          r_prdata <= '0;
        end
        default: begin
          r_state  <= IDLE;
          r_pready <= 1'b0;
          r_prdata <= '0;
        end
      endcase
    end
  end

  timer_core #(
    .CNT_W(CNT_W),
    .PSC_W(PSC_W)
  ) u_core (
    .i_clk       (PCLK),
    .i_rst       (PRESET),
    .i_wdata     (PWDATA),
    .i_wr_ctrl   (w_commit && (w_ofs == CTRL_OFS)),
    .i_wr_psc    (w_commit && (w_ofs == PSC_OFS)),
    .i_wr_arr    (w_commit && (w_ofs == ARR_OFS)),
    .i_wr_cnt    (w_commit && (w_ofs == CNT_OFS)),
    .i_wr_status (w_commit && (w_ofs == STATUS_OFS)),
    .o_ctrl      (w_ctrl),
    .o_psc       (w_psc),
    .o_arr       (w_arr),
    .o_cnt       (w_cnt),
    .o_uif       (w_uif)
  );

  assign PREADY = r_pready;
  assign PRDATA = r_prdata;
  assign irq    = w_uif & w_ctrl[CTRL_IRQ_EN_BIT];

endmodule

// File: tb/tb_apb_timer_slave.sv
module tb_apb_timer_slave;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic        PSEL;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        irq;

  apb_timer_slave #(.CNT_W(32), .PSC_W(16)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PWDATA  (PWDATA),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .irq     (irq)
  );

  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_rd;
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    string       name;
  } vec_t;
  vec_t vecs[18];

  logic prev_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every PREADY pulse retires the oldest transfer.
  always @(negedge PCLK) begin
    sb_t e;
    if (PREADY === 1'b1) begin
      chk("pready_width", {31'b0, prev_ready}, 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_pready", {31'b0, PREADY}, 32'd0);
      end else begin
        e = sbq.pop_front();
        if (e.is_rd) chk(e.name, PRDATA, e.exp);
      end
    end else if (PREADY === 1'b0 && PSEL === 1'b1) begin
      chk("prdata_idle", PRDATA, 32'd0);
    end
    prev_ready = PREADY;
  end

  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input string name);
    int  n;
    sb_t e;
    e.is_rd = !wr;
    e.exp   = data;
    e.name  = name;
    sbq.push_back(e);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = wr ? data : 32'h0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (PREADY !== 1'b1 && n < 8);
    chk({name, "_latency"}, n, 32'd3);
    if (PREADY !== 1'b1 && sbq.size() > 0) e = sbq.pop_back();
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    apb(1'b1, addr, data, "wr");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    apb(1'b0, addr, exp, name);
  endtask

  task automatic do_reset();
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    vecs[0]  = '{1'b0, 32'h00, 32'h0000_0000, "rst_ctrl"};
    vecs[1]  = '{1'b0, 32'h04, 32'h0000_0000, "rst_psc"};
    vecs[2]  = '{1'b0, 32'h08, 32'hFFFF_FFFF, "rst_arr"};
    vecs[3]  = '{1'b0, 32'h0C, 32'h0000_0000, "rst_cnt"};
    vecs[4]  = '{1'b0, 32'h10, 32'h0000_0000, "rst_status"};
    vecs[5]  = '{1'b0, 32'h14, 32'h0000_0000, "rst_unmapped"};
    vecs[6]  = '{1'b1, 32'h04, 32'h0000_0003, "wr_psc"};
    vecs[7]  = '{1'b0, 32'h04, 32'h0000_0003, "rb_psc"};
    vecs[8]  = '{1'b1, 32'h08, 32'h0000_0004, "wr_arr"};
    vecs[9]  = '{1'b0, 32'h08, 32'h0000_0004, "rb_arr"};
    vecs[10] = '{1'b1, 32'h00, 32'hFFFF_FFF6, "wr_ctrl"};
    vecs[11] = '{1'b0, 32'h00, 32'h0000_0006, "rb_ctrl_mask"};
    vecs[12] = '{1'b1, 32'h0C, 32'h0000_1234, "wr_cnt"};
    vecs[13] = '{1'b0, 32'h0C, 32'h0000_1234, "rb_cnt_hold"};
    vecs[14] = '{1'b1, 32'h14, 32'h0000_DEAD, "wr_unmapped"};
    vecs[15] = '{1'b0, 32'h14, 32'h0000_0000, "rb_unmapped"};
    vecs[16] = '{1'b0, 32'h1C, 32'h0000_0000, "rb_unmapped_1c"};
    vecs[17] = '{1'b0, 32'h04, 32'h0000_0003, "rb_psc_after_unmapped"};

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    @(negedge PCLK);
    chk("rst_pready", {31'b0, PREADY}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    @(posedge PCLK); #1 PRESET = 1'b0;

    foreach (vecs[i]) apb(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].name);

    // Auto-reload: PSC=3, ARR=4 -> match on the 20th edge after CTRL commits.
    do_reset();
    wr(32'h04, 32'd3);
    wr(32'h08, 32'd4);
    wr(32'h00, 32'h7);
    repeat (19) @(posedge PCLK);
    @(negedge PCLK);
    chk("ar_irq_before", {31'b0, irq}, 32'd0);
    @(negedge PCLK);
    chk("ar_irq_after", {31'b0, irq}, 32'd1);
    rd(32'h10, 32'd1, "ar_uif");
    rd(32'h0C, 32'd2, "ar_cnt_continues");

    // One-shot.
    do_reset();
    wr(32'h04, 32'd3);
    wr(32'h08, 32'd4);
    wr(32'h00, 32'h1);
    repeat (20) @(posedge PCLK);
    @(negedge PCLK);
    chk("os_irq", {31'b0, irq}, 32'd0);
    rd(32'h00, 32'd0, "os_en_cleared");
    rd(32'h10, 32'd1, "os_uif");
    repeat (40) @(posedge PCLK);
    rd(32'h0C, 32'd0, "os_cnt_stays");

    // W1C semantics.
    wr(32'h00, 32'h2);
    @(negedge PCLK);
    chk("w1c_irq_on", {31'b0, irq}, 32'd1);
    wr(32'h10, 32'h0);
    rd(32'h10, 32'd1, "w1c_write0");
    wr(32'h10, 32'h1);
    rd(32'h10, 32'd0, "w1c_write1");
    @(negedge PCLK);
    chk("w1c_irq_off", {31'b0, irq}, 32'd0);

    // W1C lands on the 5th edge after CTRL commits, same edge as the match.
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd4);
    wr(32'h0C, 32'd0);
    wr(32'h00, 32'h7);
    wr(32'h10, 32'h1);
    rd(32'h10, 32'd1, "w1c_vs_set");
    wr(32'h00, 32'h0);

    // CNT write on a tick edge: 50 at edge 5, read snapshot after edge 8.
    wr(32'h08, 32'd100);
    wr(32'h0C, 32'd0);
    wr(32'h00, 32'h5);
    wr(32'h0C, 32'd50);
    rd(32'h0C, 32'd53, "cnt_write_vs_tick");

    // Upper address bits ignored; unmapped write has no effect.
    do_reset();
    wr(32'h1000_0000, 32'h7);
    rd(32'h00, 32'h7, "alias_a");
    wr(32'h00, 32'h0);
    rd(32'h00, 32'h0, "alias_clear");
    wr(32'h1000_1000, 32'h7);
    rd(32'h00, 32'h7, "alias_b");
    wr(32'h18, 32'hFFFF_FFFF);
    rd(32'h04, 32'h0, "unmapped_psc");
    rd(32'h08, 32'hFFFF_FFFF, "unmapped_arr");
    rd(32'h00, 32'h7, "unmapped_ctrl");

    // PSEL drops while in WAIT: no PREADY, no commit.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'h33; PENABLE = 1'b0;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
    p = 0;
    repeat (4) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) p++;
    end
    chk("psel_drop_noready", p, 32'd0);
    rd(32'h08, 32'hFFFF_FFFF, "psel_drop_arr");

    // Reset asserted during WAIT.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'h12; PENABLE = 1'b0;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    p = 0;
    repeat (3) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) p++;
    end
    @(posedge PCLK); #1 PRESET = 1'b0;
    repeat (2) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) p++;
    end
    chk("rst_wait_noready", p, 32'd0);
    rd(32'h00, 32'h0, "rst_wait_ctrl");
    rd(32'h08, 32'hFFFF_FFFF, "rst_wait_arr");
    rd(32'h0C, 32'h0, "rst_wait_cnt");

    repeat (2) @(negedge PCLK);
    chk("sb_drain", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
